// File: rtl/servo_pwm_pkg.sv
// Shared helpers for the servo PWM bank: width derivation and parameter legality.
package servo_pwm_pkg;

  function automatic int clog2(input int unsigned v);
    int r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  // Clocks per PWM tick (integer floor).
  function automatic int div_f(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Frame counter width.
  function automatic int fw_f(input int frame_ticks);
    return clog2(frame_ticks);
  endfunction

  // Channel address width, at least one bit.
  function automatic int cw_f(input int channels);
    return (channels < 2) ? 1 : clog2(channels);
  endfunction

  // Widest pulse must leave a low interval in every frame; prescaler needs >= 2.
  function automatic bit legal_f(input int min_ticks, input int duty_w,
                                 input int frame_ticks, input int div);
    return ((min_ticks + (1 << duty_w) - 1) < frame_ticks) && (div >= 2);
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo lane: shadow/active duty pair, optional slew limit, frame-latched enable, comparator.
module servo_pwm_channel
  import servo_pwm_pkg::*;
#(
  parameter int DUTY_W    = 8,
  parameter int FW        = 12,
  parameter int SW        = 13,
  parameter int MIN_TICKS = 64,
  parameter int SLEW_STEP = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr,
  input  logic [DUTY_W-1:0] duty,
  input  logic              wrap,
  input  logic              en_in,
  input  logic [FW-1:0]     fcnt,
  output logic              pwm
);

  logic [DUTY_W-1:0] shadow, active, next_active, diff;
  logic              en_q;
  logic [SW-1:0]     thr;

  // Threshold in a widened sum so MIN_TICKS + active cannot wrap.
  assign thr = SW'(MIN_TICKS) + SW'(active);

  // Next active value at the frame boundary: jump to shadow, or step toward it without overshoot.
  always_comb begin
    next_active = shadow;
    diff        = (shadow > active) ? (shadow - active) : (active - shadow);
    if ((SLEW_STEP > 0) && (int'(diff) > SLEW_STEP))
      next_active = (shadow > active) ? (active + DUTY_W'(SLEW_STEP))
                                      : (active - DUTY_W'(SLEW_STEP));
  end

  // Shadow takes writes any time; active/enable move only on wrap, so pulses are never cut.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow <= '0;
      active <= '0;
      en_q   <= 1'b0;
      pwm    <= 1'b0;
    end else begin
      if (wr) shadow <= duty;
      if (wrap) begin
        active <= next_active;  // uses pre-write shadow when load and wrap coincide
        en_q   <= en_in;
      end
      pwm <= en_q && (SW'(fcnt) < thr);
    end
  end

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel frame-aligned servo PWM: tick prescaler, frame counter, load decode, lanes.
module servo_pwm_bank
  import servo_pwm_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 128_000,
  parameter int CHANNELS    = 4,
  parameter int DUTY_W      = 8,
  parameter int FRAME_TICKS = 2560,
  parameter int MIN_TICKS   = 64,
  parameter int SLEW_STEP   = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load,
  input  logic [cw_f(CHANNELS)-1:0]  chan,
  input  logic [DUTY_W-1:0]          duty,
  input  logic [CHANNELS-1:0]        enable,
  output logic                       frame_start,
  output logic [CHANNELS-1:0]        PWMOut
);

  localparam int DIV = div_f(CLK_HZ, TICK_HZ);
  localparam int FW  = fw_f(FRAME_TICKS);
  localparam int CW  = cw_f(CHANNELS);
  localparam int PCW = clog2(DIV);
  localparam int SW  = ((FW > DUTY_W) ? FW : DUTY_W) + 1;

  if (!legal_f(MIN_TICKS, DUTY_W, FRAME_TICKS, DIV)) begin : g_illegal
    $error("servo_pwm_bank: pulse range does not fit in frame, or DIV < 2");
  end

  logic [PCW-1:0] pcnt;
  logic [FW-1:0]  fcnt;
  logic           tick, wrap, wrap_q;

  assign tick = (pcnt == PCW'(DIV - 1));
  assign wrap = tick && (fcnt == FW'(FRAME_TICKS - 1));

  // Prescaler and frame counter; frame_start trails the wrap by two edges so it lines up
  // with the first PWMOut sample computed from the new active values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pcnt        <= '0;
      fcnt        <= '0;
      wrap_q      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PCW'(1);
      if (tick) fcnt <= wrap ? '0 : fcnt + FW'(1);
      wrap_q      <= wrap;
      frame_start <= wrap_q;
    end
  end

  // Out-of-range chan values match no lane, so those loads are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    servo_pwm_channel #(
      .DUTY_W   (DUTY_W),
      .FW       (FW),
      .SW       (SW),
      .MIN_TICKS(MIN_TICKS),
      .SLEW_STEP(SLEW_STEP)
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .wr   (load && (chan == CW'(i))),
      .duty (duty),
      .wrap (wrap),
      .en_in(enable[i]),
      .fcnt (fcnt),
      .pwm  (PWMOut[i])
    );
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Scoreboard bench: stimulus pushes per-frame expected pulse widths, a monitor measures
// each frame between frame_start pulses and compares. DIV=10, frame = 400 clocks.
module tb_servo_pwm_bank;

  localparam int CH = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0, load_s = 1'b0;
  logic [1:0]    chan = '0, chan_s = '0;
  logic [3:0]    duty = '0, duty_s = '0;
  logic [CH-1:0] enable = '1;
  logic          frame_start, frame_start_s;
  logic [CH-1:0] PWMOut, PWMOut_s;

  typedef struct {
    int w0;
    int w1;
    int w2;
    int ws;
    bit chk_len;
  } exp_t;

  exp_t exp_q[$];
  int   rst_q[$];
  int   checks = 0, errors = 0;
  int   hi0 = 0, hi1 = 0, hi2 = 0, his = 0, len = 0;
  bit   fin = 1'b0, fin_done = 1'b0;
  int   cyc = 0;

  always #5 clock = ~clock;

  servo_pwm_bank #(
    .CLK_HZ(1000), .TICK_HZ(100), .CHANNELS(CH), .DUTY_W(4),
    .FRAME_TICKS(40), .MIN_TICKS(4), .SLEW_STEP(0)
  ) dut (
    .clock(clock), .reset(reset), .load(load), .chan(chan), .duty(duty),
    .enable(enable), .frame_start(frame_start), .PWMOut(PWMOut)
  );

  servo_pwm_bank #(
    .CLK_HZ(1000), .TICK_HZ(100), .CHANNELS(CH), .DUTY_W(4),
    .FRAME_TICKS(40), .MIN_TICKS(4), .SLEW_STEP(4)
  ) dut_s (
    .clock(clock), .reset(reset), .load(load_s), .chan(chan_s), .duty(duty_s),
    .enable(enable), .frame_start(frame_start_s), .PWMOut(PWMOut_s)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: all comparisons happen here.
  always @(negedge clock or posedge reset) begin
    if (reset) begin
      if (rst_q.size() > 0) begin
        int tok;
        tok = rst_q.pop_front();
        #1;
        chk("rst_pwm", int'(PWMOut), 0);
        chk("rst_pwm_slew", int'(PWMOut_s), 0);
        chk("rst_frame_start", int'(frame_start), 0);
      end
      hi0 = 0; hi1 = 0; hi2 = 0; his = 0; len = 0;
    end else begin
      if (frame_start) begin
        chk("frame_start_slew_dut", int'(frame_start_s), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got a frame end, expected none queued");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("width_ch0", hi0, e.w0);
          chk("width_ch1", hi1, e.w1);
          chk("width_ch2", hi2, e.w2);
          chk("width_slew_ch0", his, e.ws);
          if (e.chk_len) chk("frame_len", len, 400);
        end
        hi0 = 0; hi1 = 0; hi2 = 0; his = 0; len = 0;
      end
      len++;
      hi0 += int'(PWMOut[0]);
      hi1 += int'(PWMOut[1]);
      hi2 += int'(PWMOut[2]);
      his += int'(PWMOut_s[0]);
      if (len == 1000) chk("frame_timeout_len", len, 400);
      if (fin && !fin_done) begin
        fin_done = 1'b1;
        chk("queue_empty", exp_q.size(), 0);
      end
    end
  end

  task automatic push(input int a, input int b, input int c, input int s, input bit l);
    exp_t e;
    e.w0 = a; e.w1 = b; e.w2 = c; e.ws = s; e.chk_len = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_start && n < 1100);
    if (!frame_start) begin
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
    cyc = 0;
  endtask

  task automatic at(input int c);
    while (cyc < c) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic ld(input int ch, input int d, input bit slew);
    if (slew) begin
      chan_s = 2'(ch); duty_s = 4'(d); load_s = 1'b1;
    end else begin
      chan = 2'(ch); duty = 4'(d); load = 1'b1;
    end
    @(negedge clock);
    cyc++;
    load = 1'b0;
    load_s = 1'b0;
  endtask

  // Widths in clocks: (4 + active) * 10.
  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    push(0, 0, 0, 0, 1'b0);                         // first frame: enables not latched yet
    wait_fs(); push(40, 40, 40, 40, 1'b1);
    wait_fs(); push(40, 40, 40, 40, 1'b1);          // load lands mid-frame, frame unaffected
    at(100); ld(1, 15, 1'b0); ld(0, 15, 1'b1);
    wait_fs(); push(40, 190, 40, 80, 1'b1);         // slew: 0 -> 4
    at(50); ld(2, 5, 1'b0); at(60); ld(2, 9, 1'b0);
    wait_fs(); push(40, 190, 130, 120, 1'b1);       // last load wins; slew 8
    at(398); ld(0, 7, 1'b0);                        // sampled on the wrap edge
    wait_fs(); push(40, 190, 130, 160, 1'b1);       // old width kept; slew 12
    at(50); ld(3, 0, 1'b0);                         // out-of-range channel
    wait_fs(); push(110, 190, 130, 190, 1'b1);      // wrap-cycle load now active; slew 15
    at(20); enable = 3'b110;                        // mid-pulse: this pulse completes
    wait_fs(); push(0, 190, 130, 0, 1'b1);
    wait_fs();
    at(50);                                         // ch1/ch2 high here
    rst_q.push_back(1);
    #2 reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    fin = 1'b1;
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
